// File: rtl/antares_pipe_register.sv
// -----------------------------------------------------------------------------
// antares_pipe_register
//
// Reusable pipeline stage register placed between any two Antares stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds one instruction, or two when SKID=1.
//
// Parameters
//   DATA_W : payload width; the payload is held across bubbles.
//   CTRL_W : control width; control is forced to zero when no entry is valid.
//   SKID   : 1 = main + skid entry, up_ready_o comes straight from a flop.
//            0 = main entry only, up_ready_o is combinational on down_ready_i.
//   CNT_W  : width of the saturating stall counter.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   up_valid_i/up_data_i/up_ctrl_i/up_ready_o       upstream handshake
//   down_valid_o/down_data_o/down_ctrl_o/down_ready_i downstream handshake
//   flush_i                kill every entry held in this stage
//   clr_stat_i             clear the stall counter
//   stall_cnt_o            cycles with down_valid_o=1 and down_ready_i=0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready. Accept = up_valid_i & up_ready_o,
// consume = down_valid_o & down_ready_i. A flush drops any accept of that
// cycle (upstream still counts it as transferred) but the consume of that
// cycle is a real transfer because downstream sampled it.
// -----------------------------------------------------------------------------
module antares_pipe_register #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 8,
   parameter bit          SKID   = 1'b1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   input  logic [CTRL_W-1:0] up_ctrl_i,
   output logic              up_ready_o,
   output logic              down_valid_o,
   output logic [DATA_W-1:0] down_data_o,
   output logic [CTRL_W-1:0] down_ctrl_o,
   input  logic              down_ready_i,
   input  logic              flush_i,
   input  logic              clr_stat_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;

   logic accept;
   logic consume;

   // With a skid entry, ready only reflects whether the skid slot is free, so
   // downstream stalls never ripple combinationally into the upstream stage.
   assign up_ready_o   = SKID ? ~s_valid_q : (~m_valid_q | down_ready_i);
   assign accept       = up_valid_i & up_ready_o;
   assign consume      = m_valid_q & down_ready_i;

   assign down_valid_o = m_valid_q;
   assign down_data_o  = m_data_q;
   assign down_ctrl_o  = m_valid_q ? m_ctrl_q : '0;
   assign stall_cnt_o  = cnt_q;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;

      if (flush_i) begin
         // Only the valid bits die; payload registers keep their last value.
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (SKID) begin
         if (consume) begin
            if (s_valid_q) begin
               // up_ready_o is low here, so no accept can collide with this.
               m_data_d  = s_data_q;
               m_ctrl_d  = s_ctrl_q;
               s_valid_d = 1'b0;
            end else if (accept) begin
               m_data_d = up_data_i;
               m_ctrl_d = up_ctrl_i;
            end else begin
               m_valid_d = 1'b0;
            end
         end else if (accept) begin
            if (!m_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = up_data_i;
               m_ctrl_d  = up_ctrl_i;
            end else begin
               s_valid_d = 1'b1;
               s_data_d  = up_data_i;
               s_ctrl_d  = up_ctrl_i;
            end
         end
      end else begin
         if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = up_data_i;
            m_ctrl_d  = up_ctrl_i;
         end else if (consume) begin
            m_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_stat_i) begin
         cnt_d = '0;
      end else if (m_valid_q && !down_ready_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ctrl_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_ctrl_q  <= '0;
         cnt_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_ctrl_q  <= s_ctrl_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_antares_pipe_register.sv
// -----------------------------------------------------------------------------
// tb_antares_pipe_register
//
// Drives one shared stimulus into two stage instances: u_s0 (SKID=0, 16-bit
// counter) and u_s1 (SKID=1, 4-bit counter). A FIFO-style model of each stage
// predicts every output; a negedge process compares both instances against it
// every cycle, and directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_antares_pipe_register;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        up_valid;
   logic [63:0] up_data;
   logic [7:0]  up_ctrl;
   logic        down_ready;
   logic        flush;
   logic        clr_stat;

   logic        ur0, dv0, ur1, dv1;
   logic [63:0] dd0, dd1;
   logic [7:0]  dc0, dc1;
   logic [15:0] st0;
   logic [3:0]  st1;

   antares_pipe_register #(.DATA_W(64), .CTRL_W(8), .SKID(1'b0), .CNT_W(16)) u_s0 (
      .clk_i(clk), .rst_ni(rst_n),
      .up_valid_i(up_valid), .up_data_i(up_data), .up_ctrl_i(up_ctrl), .up_ready_o(ur0),
      .down_valid_o(dv0), .down_data_o(dd0), .down_ctrl_o(dc0), .down_ready_i(down_ready),
      .flush_i(flush), .clr_stat_i(clr_stat), .stall_cnt_o(st0)
   );

   antares_pipe_register #(.DATA_W(64), .CTRL_W(8), .SKID(1'b1), .CNT_W(4)) u_s1 (
      .clk_i(clk), .rst_ni(rst_n),
      .up_valid_i(up_valid), .up_data_i(up_data), .up_ctrl_i(up_ctrl), .up_ready_o(ur1),
      .down_valid_o(dv1), .down_data_o(dd1), .down_ctrl_o(dc1), .down_ready_i(down_ready),
      .flush_i(flush), .clr_stat_i(clr_stat), .stall_cnt_o(st1)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each stage is an in-order FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
   logic [63:0] md[2][2];
   logic [7:0]  mc[2][2];
   int          mn[2];
   logic [63:0] mlast[2];
   int          mcnt[2];

   function automatic int cnt_max(input int d);
      return (d == 1) ? 15 : 65535;
   endfunction

   function automatic bit model_ready(input int d);
      if (d == 1) return (mn[1] < 2);
      return (mn[0] == 0) || down_ready;
   endfunction

   function automatic logic [7:0] model_ctrl(input int d);
      return (mn[d] > 0) ? mc[d][0] : 8'h00;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mn[d]    = 0;
         mlast[d] = '0;
         mcnt[d]  = 0;
         for (int k = 0; k < 2; k++) begin
            md[d][k] = '0;
            mc[d][k] = '0;
         end
      end
   endtask

   task automatic model_step();
      if (!rst_n) return;
      for (int d = 0; d < 2; d++) begin
         bit ur, cons, acc;
         ur   = model_ready(d);
         cons = (mn[d] > 0) && down_ready;
         acc  = up_valid && ur;
         if (clr_stat) mcnt[d] = 0;
         else if ((mn[d] > 0) && !down_ready && (mcnt[d] < cnt_max(d))) mcnt[d]++;
         if (cons) begin
            md[d][0] = md[d][1];
            mc[d][0] = mc[d][1];
            mn[d]--;
         end
         if (flush) mn[d] = 0;
         else if (acc) begin
            md[d][mn[d]] = up_data;
            mc[d][mn[d]] = up_ctrl;
            mn[d]++;
         end
         if (mn[d] > 0) mlast[d] = md[d][0];
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("s0.up_ready",   {63'd0, ur0}, {63'd0, model_ready(0)});
      chk("s0.down_valid", {63'd0, dv0}, (mn[0] > 0) ? 64'd1 : 64'd0);
      chk("s0.down_data",  dd0, mlast[0]);
      chk("s0.down_ctrl",  {56'd0, dc0}, {56'd0, model_ctrl(0)});
      chk("s0.stall_cnt",  {48'd0, st0}, 64'(mcnt[0]));
      chk("s1.up_ready",   {63'd0, ur1}, {63'd0, model_ready(1)});
      chk("s1.down_valid", {63'd0, dv1}, (mn[1] > 0) ? 64'd1 : 64'd0);
      chk("s1.down_data",  dd1, mlast[1]);
      chk("s1.down_ctrl",  {56'd0, dc1}, {56'd0, model_ctrl(1)});
      chk("s1.stall_cnt",  {60'd0, st1}, 64'(mcnt[1]));
   end

   // ---------------- driver tasks ----------------
   // Advance one edge: the model sees the pre-edge inputs, then inputs may
   // change 1 time unit later, away from the edge.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic offer(input logic v, input logic [63:0] d, input logic [7:0] c);
      up_valid = v;
      up_data  = d;
      up_ctrl  = c;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b0;
      offer(1'b0, 64'd0, 8'd0);
      down_ready = 1'b0;
      flush      = 1'b0;
      clr_stat   = 1'b0;
      model_reset();
      repeat (2) step();
      chk("lit.reset.s1.up_ready", {63'd0, ur1}, 64'd1);
      chk("lit.reset.s0.up_ready", {63'd0, ur0}, 64'd1);
      chk("lit.reset.s1.down_valid", {63'd0, dv1}, 64'd0);
      rst_n = 1'b1;

      // streaming 1,2,3 with downstream always ready
      down_ready = 1'b1;
      offer(1'b1, 64'h1, 8'h11);
      step();
      chk("lit.stream.data1", dd1, 64'h1);
      chk("lit.stream.ready1", {63'd0, ur1}, 64'd1);
      offer(1'b1, 64'h2, 8'h12);
      step();
      chk("lit.stream.data2", dd1, 64'h2);
      offer(1'b1, 64'h3, 8'h13);
      step();
      chk("lit.stream.data3", dd1, 64'h3);
      chk("lit.stream.ready3", {63'd0, ur1}, 64'd1);
      offer(1'b0, 64'h0, 8'h00);
      step();
      chk("lit.stream.drained", {63'd0, dv1}, 64'd0);

      // backpressure: A then B into the skid stage
      down_ready = 1'b0;
      offer(1'b1, 64'hA, 8'h0A);
      step();
      chk("lit.bp.a_main", dd1, 64'hA);
      offer(1'b1, 64'hB, 8'h0B);
      step();
      chk("lit.bp.full_ready", {63'd0, ur1}, 64'd0);
      chk("lit.bp.a_still", dd1, 64'hA);
      offer(1'b0, 64'h0, 8'h00);
      down_ready = 1'b1;
      step();
      chk("lit.bp.b_next", dd1, 64'hB);
      chk("lit.bp.ready_back", {63'd0, ur1}, 64'd1);
      step();
      chk("lit.bp.empty", {63'd0, dv1}, 64'd0);

      // flush collision: both entries full, consume + offer C + flush together
      down_ready = 1'b0;
      offer(1'b1, 64'h21, 8'h21);
      step();
      offer(1'b1, 64'h22, 8'h22);
      step();
      chk("lit.flush.full", {63'd0, ur1}, 64'd0);
      chk("lit.flush.main", dd1, 64'h21);
      flush      = 1'b1;
      down_ready = 1'b1;
      offer(1'b1, 64'hCC, 8'hCC);
      step();
      chk("lit.flush.s1_valid", {63'd0, dv1}, 64'd0);
      chk("lit.flush.s1_ctrl", {56'd0, dc1}, 64'd0);
      chk("lit.flush.s1_held", dd1, 64'h21);
      chk("lit.flush.s0_valid", {63'd0, dv0}, 64'd0);
      flush = 1'b0;
      offer(1'b0, 64'h0, 8'h00);
      repeat (3) step();

      // bubble gating on the single-entry stage
      offer(1'b1, 64'h5A5A, 8'hA5);
      step();
      chk("lit.bubble.ctrl_live", {56'd0, dc0}, 64'hA5);
      offer(1'b0, 64'h0, 8'h00);
      step();
      chk("lit.bubble.valid", {63'd0, dv0}, 64'd0);
      chk("lit.bubble.ctrl", {56'd0, dc0}, 64'd0);
      chk("lit.bubble.data", dd0, 64'h5A5A);

      // stall counter saturation and clear
      down_ready = 1'b0;
      clr_stat   = 1'b1;
      offer(1'b1, 64'h77, 8'h77);
      step();
      chk("lit.cnt.cleared", {60'd0, st1}, 64'd0);
      clr_stat = 1'b0;
      offer(1'b0, 64'h0, 8'h00);
      repeat (20) step();
      chk("lit.cnt.saturated", {60'd0, st1}, 64'd15);
      clr_stat = 1'b1;
      step();
      chk("lit.cnt.clr", {60'd0, st1}, 64'd0);
      clr_stat = 1'b0;
      step();
      chk("lit.cnt.restart", {60'd0, st1}, 64'd1);

      // asynchronous reset with a live ctrl of 8'hFF
      flush = 1'b1;
      step();
      flush = 1'b0;
      offer(1'b1, 64'h99, 8'hFF);
      step();
      chk("lit.rst.ctrl_ff", {56'd0, dc1}, 64'hFF);
      offer(1'b0, 64'h0, 8'h00);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("lit.rst.s1_valid", {63'd0, dv1}, 64'd0);
      chk("lit.rst.s1_ctrl", {56'd0, dc1}, 64'd0);
      chk("lit.rst.s1_cnt", {60'd0, st1}, 64'd0);
      chk("lit.rst.s1_ready", {63'd0, ur1}, 64'd1);
      chk("lit.rst.s0_ctrl", {56'd0, dc0}, 64'd0);
      chk("lit.rst.s0_ready", {63'd0, ur0}, 64'd1);
      step();
      rst_n      = 1'b1;
      down_ready = 1'b1;
      offer(1'b1, 64'h42, 8'h42);
      step();
      chk("lit.rst.first_accept", {63'd0, dv1}, 64'd1);
      chk("lit.rst.first_data", dd1, 64'h42);
      offer(1'b0, 64'h0, 8'h00);
      repeat (2) step();

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
